// File: rtl/std_cache_pkg.sv
// Shared std cache types: bypass request/response bundles
// and the bypass arbiter state encoding.
package std_cache_pkg;

   localparam int unsigned BYP_ID_W = 4;

   typedef struct packed {
      logic                req;
      logic                we;
      logic                amo;
      logic [7:0]          be;
      logic [1:0]          size;
      logic [BYP_ID_W-1:0] id;
      logic [63:0]         addr;
      logic [63:0]         wdata;
   } bypass_req_t;

   typedef struct packed {
      logic        gnt;
      logic        valid;
      logic [63:0] rdata;
   } bypass_rsp_t;

   typedef enum logic [1:0] {
      BYP_IDLE,
      BYP_SEND,
      BYP_WAIT
   } bypass_arb_state_e;

   // Port after the one just served, wrapping to 0.
   function automatic logic [BYP_ID_W-1:0] byp_next_ptr(
      input logic [BYP_ID_W-1:0] sel,
      input int unsigned         n
   );
      return (sel == BYP_ID_W'(n - 1)) ? '0 : sel + 1'b1;
   endfunction

endpackage

// File: rtl/std_cache_rr_picker.sv
// Combinational round-robin picker: first requesting port at or after
// i_rr_ptr. Ports: i_req, i_rr_ptr in; o_gnt (onehot), o_idx, o_any out.
module std_cache_rr_picker
   import std_cache_pkg::*;
#(
   parameter int unsigned NR_PORTS = 3
) (
   input  logic [NR_PORTS-1:0] i_req,
   input  logic [BYP_ID_W-1:0] i_rr_ptr,
   output logic [NR_PORTS-1:0] o_gnt,
   output logic [BYP_ID_W-1:0] o_idx,
   output logic                o_any
);

   always_comb begin
      int   k;
      logic found;
      k     = 0;
      found = 1'b0;
      o_gnt = '0;
      o_idx = '0;
      for (int i = 0; i < int'(NR_PORTS); i++) begin
         k = int'(i_rr_ptr) + i;
         if (k >= int'(NR_PORTS)) k = k - int'(NR_PORTS);
         if (!found && i_req[k]) begin
            found    = 1'b1;
            o_gnt[k] = 1'b1;
            o_idx    = BYP_ID_W'(k);
         end
      end
      o_any = found;
   end

endmodule

// File: rtl/std_cache_bypass_arbiter.sv
// Single-outstanding arbiter of bypass requesters onto one memory port.
// Ports: clk_i, rst_ni, bypass_req_i/rsp_o, mem_req_o, mem_gnt_i,
// mem_valid_i, mem_rdata_i, unexp_rsp_o.
module std_cache_bypass_arbiter
   import std_cache_pkg::*;
#(
   parameter int unsigned NR_PORTS = 3
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  bypass_req_t [NR_PORTS-1:0] bypass_req_i,
   output bypass_rsp_t [NR_PORTS-1:0] bypass_rsp_o,
   output bypass_req_t                mem_req_o,
   input  logic                       mem_gnt_i,
   input  logic                       mem_valid_i,
   input  logic [63:0]                mem_rdata_i,
   output logic                       unexp_rsp_o
);

   bypass_arb_state_e   r_state;
   logic [BYP_ID_W-1:0] r_rr_ptr;
   logic [BYP_ID_W-1:0] r_sel_q;
   bypass_req_t         r_req_q;

   logic [NR_PORTS-1:0] w_req_vec;
   logic [NR_PORTS-1:0] w_pick_gnt;
   logic [BYP_ID_W-1:0] w_idx;
   logic                w_any;
   logic                w_rsp_fire;
   bypass_req_t         w_win_req;

   always_comb begin
      w_req_vec = '0;
      for (int k = 0; k < int'(NR_PORTS); k++)
         w_req_vec[k] = bypass_req_i[k].req;
   end

   std_cache_rr_picker #(
      .NR_PORTS (NR_PORTS)
   ) u_picker (
      .i_req    (w_req_vec),
      .i_rr_ptr (r_rr_ptr),
      .o_gnt    (w_pick_gnt),
      .o_idx    (w_idx),
      .o_any    (w_any)
   );

   // Winner's request with the id field replaced by its port index.
   always_comb begin
      w_win_req = '0;
      for (int k = 0; k < int'(NR_PORTS); k++)
         if (w_pick_gnt[k]) w_win_req = bypass_req_i[k];
      w_win_req.id = w_idx;
   end

   // A response is accepted in WAIT, or in SEND when gnt and valid coincide.
   assign w_rsp_fire = mem_valid_i &&
                       ((r_state == BYP_WAIT) ||
                        ((r_state == BYP_SEND) && mem_gnt_i));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state  <= BYP_IDLE;
         r_rr_ptr <= '0;
         r_sel_q  <= '0;
         r_req_q  <= '0;
      end else begin
         unique case (r_state)
            BYP_IDLE: begin
               if (w_any) begin
                  r_req_q <= w_win_req;
                  r_sel_q <= w_idx;
                  r_state <= BYP_SEND;
               end
            end
            BYP_SEND: begin
               if (mem_gnt_i) begin
                  if (mem_valid_i) begin
                     r_rr_ptr <= byp_next_ptr(r_sel_q, NR_PORTS);
                     r_state  <= BYP_IDLE;
                  end else begin
                     r_state  <= BYP_WAIT;
                  end
               end
            end
            BYP_WAIT: begin
               if (mem_valid_i) begin
                  r_rr_ptr <= byp_next_ptr(r_sel_q, NR_PORTS);
                  r_state  <= BYP_IDLE;
               end
            end
            default: r_state <= BYP_IDLE;
         endcase
      end
   end

   // Outputs are held at zero while reset is asserted.
   always_comb begin
      bypass_rsp_o = '0;
      mem_req_o    = '0;
      unexp_rsp_o  = 1'b0;
      if (rst_ni) begin
         if (r_state == BYP_IDLE)
            for (int k = 0; k < int'(NR_PORTS); k++)
               bypass_rsp_o[k].gnt = w_pick_gnt[k];
         if (r_state == BYP_SEND) begin
            mem_req_o     = r_req_q;
            mem_req_o.req = 1'b1;
         end
         if (w_rsp_fire)
            for (int k = 0; k < int'(NR_PORTS); k++)
               if (BYP_ID_W'(k) == r_sel_q) begin
                  bypass_rsp_o[k].valid = 1'b1;
                  bypass_rsp_o[k].rdata = mem_rdata_i;
               end
         unexp_rsp_o = mem_valid_i && !w_rsp_fire;
      end
   end

endmodule
